// File: rtl/filtro_secuenciador_pkg.sv
// filtro_secuenciador_pkg
//   Shared definitions for the filter sequencer and the FiltroTop datapath:
//   FSM state codes, default timing parameters and counter widths.
package filtro_secuenciador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    FLUSH = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int DIV_DEF  = 17;
  localparam int TAPS_DEF = 5;
  localparam int PIPE_DEF = 2;

  localparam int TAP_W   = 4;
  localparam int FLUSH_W = 8;

  // Shortest sample period that fits LOAD + MAC + FLUSH + WRITE + one IDLE cycle.
  function automatic int min_div(input int taps, input int pipe);
    return taps + pipe + 3;
  endfunction

endpackage

// File: rtl/filtro_secuenciador_if.sv
// filtro_secuenciador_if
//   Control bundle between the sequencer (master) and the MAC datapath (slave).
//   en, sample_stb_i           : run enable and external sample strobe into the sequencer
//   clk_r                      : sample-rate clock
//   sample_ld, acc_clr, acc_en : delay-line load, accumulator clear / enable
//   tap_addr                   : coefficient ROM and delay-line tap index
//   out_ld                     : output register load
//   busy, overrun              : status
interface filtro_secuenciador_if;
  import filtro_secuenciador_pkg::*;

  logic             en;
  logic             sample_stb_i;
  logic             clk_r;
  logic             sample_ld;
  logic             acc_clr;
  logic             acc_en;
  logic [TAP_W-1:0] tap_addr;
  logic             out_ld;
  logic             busy;
  logic             overrun;

  modport master (
    input  en, sample_stb_i,
    output clk_r, sample_ld, acc_clr, acc_en, tap_addr, out_ld, busy, overrun
  );

  modport slave (
    output en, sample_stb_i,
    input  clk_r, sample_ld, acc_clr, acc_en, tap_addr, out_ld, busy, overrun
  );

endinterface

// File: rtl/filtro_secuenciador_divisor_muestreo.sv
// divisor_muestreo
//   Sample-rate divider. cnt runs 0..DIV-1 while en=1 and freezes while en=0.
//   Ports:
//     clk, rst      : system clock, synchronous active-low reset
//     en            : run enable
//     sample_stb_i  : external sample strobe (only when EXT_STB=1)
//     tick          : sample tick, combinational, one cycle wide
//     clk_r         : registered sample-rate clock
module divisor_muestreo #(
  parameter int DIV     = 17,
  parameter int EXT_STB = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sample_stb_i,
  output logic tick,
  output logic clk_r
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_comb begin
    cnt_nx = cnt;
    if (en) begin
      cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (EXT_STB != 0) ? (sample_stb_i && en) : ((cnt == '0) && en);

  // clk_r is registered from the next count so it is high exactly while cnt < DIV/2
  // and never glitches on the counter decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      clk_r <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      clk_r <= (EXT_STB != 0) ? tick : (cnt_nx < HALF);
    end
  end

endmodule

// File: rtl/filtro_secuenciador.sv
// filtro_secuenciador
//   Control sequencer for the filter MAC datapath. Per sample tick it loads the
//   delay line, runs TAPS multiply-accumulate cycles, flushes the multiplier
//   pipe and loads the output register. No data path inside.
//   Ports:
//     clk, rst : system clock, synchronous active-low reset
//     bus      : filtro_secuenciador_if.master (enable/strobe in, strobes and status out)
//
//   state | meaning
//   IDLE  | waiting for a sample tick
//   LOAD  | capture sample into delay line, clear accumulator
//   MAC   | accumulate tap 0..TAPS-1, one per cycle
//   FLUSH | PIPE cycles to drain the multiplier pipeline
//   WRITE | load saturated accumulator into the output register
module filtro_secuenciador
  import filtro_secuenciador_pkg::*;
#(
  parameter int DIV     = DIV_DEF,
  parameter int TAPS    = TAPS_DEF,
  parameter int PIPE    = PIPE_DEF,
  parameter int EXT_STB = 0
) (
  input  logic clk,
  input  logic rst,
  filtro_secuenciador_if.master bus
);

  generate
    if (EXT_STB == 0 && DIV < min_div(TAPS, PIPE)) begin : g_div_check
      $fatal(1, "filtro_secuenciador: DIV too small for TAPS+PIPE+3");
    end
    if (TAPS < 1 || TAPS > 16) begin : g_taps_check
      $fatal(1, "filtro_secuenciador: TAPS must be 1..16");
    end
  endgenerate

  localparam logic [TAP_W-1:0]   TAP_LAST   = TAP_W'(TAPS - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'((PIPE > 0) ? PIPE - 1 : 0);

  logic tick;
  logic clk_r_div;

  divisor_muestreo #(
    .DIV     (DIV),
    .EXT_STB (EXT_STB)
  ) u_div (
    .clk          (clk),
    .rst          (rst),
    .en           (bus.en),
    .sample_stb_i (bus.sample_stb_i),
    .tick         (tick),
    .clk_r        (clk_r_div)
  );

  state_t             state_q, state_nx;
  logic [TAP_W-1:0]   tap_q, tap_nx;
  logic [FLUSH_W-1:0] flush_q, flush_nx;
  logic sample_ld_q, acc_clr_q, acc_en_q, out_ld_q, busy_q, overrun_q;
  logic sample_ld_nx, acc_clr_nx, acc_en_nx, out_ld_nx, busy_nx;

  always_comb begin
    state_nx = state_q;
    tap_nx   = tap_q;
    flush_nx = flush_q;
    case (state_q)
      IDLE: begin
        tap_nx = '0;
        if (tick) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = MAC;
        tap_nx   = '0;
      end
      MAC: begin
        if (tap_q == TAP_LAST) begin
          // tap_addr holds the last tap through FLUSH and WRITE
          if (PIPE == 0) begin
            state_nx = WRITE;
          end else begin
            state_nx = FLUSH;
            flush_nx = FLUSH_INIT;
          end
        end else begin
          tap_nx = tap_q + 1'b1;
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_nx = WRITE;
        else               flush_nx = flush_q - 1'b1;
      end
      WRITE: begin
        state_nx = IDLE;
        tap_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        tap_nx   = '0;
      end
    endcase

    // Strobes are decoded from the next state so they leave a flop in step with it.
    sample_ld_nx = (state_nx == LOAD);
    acc_clr_nx   = (state_nx == LOAD);
    acc_en_nx    = (state_nx == MAC);
    out_ld_nx    = (state_nx == WRITE);
    busy_nx      = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      flush_q     <= '0;
      sample_ld_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_ld_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_nx;
      tap_q       <= tap_nx;
      flush_q     <= flush_nx;
      sample_ld_q <= sample_ld_nx;
      acc_clr_q   <= acc_clr_nx;
      acc_en_q    <= acc_en_nx;
      out_ld_q    <= out_ld_nx;
      busy_q      <= busy_nx;
      // A tick during a running sequence is dropped but remembered until reset.
      overrun_q   <= overrun_q | (tick && (state_q != IDLE));
    end
  end

  assign bus.clk_r     = clk_r_div;
  assign bus.sample_ld = sample_ld_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.tap_addr  = tap_q;
  assign bus.out_ld    = out_ld_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_filtro_secuenciador.sv
module tb_filtro_secuenciador;
  import filtro_secuenciador_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  filtro_secuenciador_if bus0 ();
  filtro_secuenciador_if bus1 ();

  filtro_secuenciador #(.DIV(17), .TAPS(5), .PIPE(2), .EXT_STB(0)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0.master)
  );

  filtro_secuenciador #(.DIV(17), .TAPS(5), .PIPE(2), .EXT_STB(1)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {clk_r, sample_ld, acc_clr, acc_en, out_ld, busy}
  function automatic int strobes0();
    return int'({bus0.clk_r, bus0.sample_ld, bus0.acc_clr, bus0.acc_en, bus0.out_ld, bus0.busy});
  endfunction

  function automatic int all_out(input int which);
    if (which == 0)
      return int'({bus0.clk_r, bus0.sample_ld, bus0.acc_clr, bus0.acc_en, bus0.tap_addr,
                   bus0.out_ld, bus0.busy, bus0.overrun});
    return int'({bus1.clk_r, bus1.sample_ld, bus1.acc_clr, bus1.acc_en, bus1.tap_addr,
                 bus1.out_ld, bus1.busy, bus1.overrun});
  endfunction

  typedef struct {
    int       k;
    logic     clk_r, sample_ld, acc_clr, acc_en, out_ld, busy;
    bit       chk_tap;
    int       tap;
  } vec_t;

  function automatic vec_t mk(input int k, input logic c, input logic l, input logic cl,
                              input logic e, input logic o, input logic b,
                              input bit ct, input int t);
    vec_t v;
    v.k = k; v.clk_r = c; v.sample_ld = l; v.acc_clr = cl; v.acc_en = e;
    v.out_ld = o; v.busy = b; v.chk_tap = ct; v.tap = t;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int outs, clk_hi, ov_seen, lds, out_at, first;

    //            k  clk ld clr en out busy chk tap
    tbl[0]  = mk( 1, 1, 1, 1, 0, 0, 1, 1, 0);
    tbl[1]  = mk( 2, 1, 0, 0, 1, 0, 1, 1, 0);
    tbl[2]  = mk( 3, 1, 0, 0, 1, 0, 1, 1, 1);
    tbl[3]  = mk( 4, 1, 0, 0, 1, 0, 1, 1, 2);
    tbl[4]  = mk( 5, 1, 0, 0, 1, 0, 1, 1, 3);
    tbl[5]  = mk( 6, 1, 0, 0, 1, 0, 1, 1, 4);
    tbl[6]  = mk( 7, 1, 0, 0, 0, 0, 1, 1, 4);
    tbl[7]  = mk( 8, 0, 0, 0, 0, 0, 1, 1, 4);
    tbl[8]  = mk( 9, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[9]  = mk(10, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(11, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(12, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(13, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(14, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(15, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(16, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(17, 1, 0, 0, 0, 0, 0, 0, 0);

    rst0 = 1'b0; rst1 = 1'b0;
    bus0.en = 1'b1; bus0.sample_stb_i = 1'b0;
    bus1.en = 1'b1; bus1.sample_stb_i = 1'b0;

    // 1. reset held three cycles: everything low
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs_dut0", all_out(0), 0);
      chk("reset_outputs_dut1", all_out(1), 0);
    end
    rst0 = 1'b1; rst1 = 1'b1;   // this cycle is T: cnt==0, en=1

    // 2. one full period from the first tick
    foreach (tbl[i]) begin
      step();
      chk($sformatf("period_k%0d", tbl[i].k), strobes0(),
          int'({tbl[i].clk_r, tbl[i].sample_ld, tbl[i].acc_clr, tbl[i].acc_en,
                tbl[i].out_ld, tbl[i].busy}));
      if (tbl[i].chk_tap)
        chk($sformatf("tap_k%0d", tbl[i].k), int'(bus0.tap_addr), tbl[i].tap);
    end

    // 3. 400 sample periods
    outs = 0; clk_hi = 0; ov_seen = 0;
    for (int i = 0; i < 6800; i++) begin
      step();
      outs    += int'(bus0.out_ld);
      clk_hi  += int'(bus0.clk_r);
      ov_seen += int'(bus0.overrun);
    end
    chk("run400_out_ld", outs, 400);
    chk("run400_clk_r_high", clk_hi, 3200);
    chk("run400_overrun", ov_seen, 0);

    // 5. this cycle is a tick (T); drop en at T+3
    outs = 0; out_at = -1; lds = 0;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 3) bus0.en = 1'b0;
      if (bus0.out_ld) begin outs++; out_at = j; end
      if (bus0.sample_ld) lds++;
    end
    chk("en_drop_load_once", lds, 1);
    chk("en_drop_out_ld_count", outs, 1);
    chk("en_drop_out_ld_at", out_at, 9);
    lds = 0; outs = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      lds  += int'(bus0.sample_ld);
      outs += int'(bus0.busy);
    end
    chk("en_low_no_load", lds, 0);
    chk("en_low_not_busy", outs, 0);
    chk("en_low_cnt_frozen", int'(dut0.u_div.cnt), 3);
    chk("en_low_clk_r", int'(bus0.clk_r), 1);

    // en rises with cnt=3: tick when cnt wraps to 0, LOAD one cycle later
    bus0.en = 1'b1;
    first = -1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (bus0.sample_ld) begin first = j; break; end
    end
    chk("en_rise_first_load", first, 15);

    // 6. reset during MAC at T+5 (now at T+1)
    for (int j = 0; j < 4; j++) step();
    chk("mid_mac_acc_en", int'(bus0.acc_en), 1);
    chk("mid_mac_tap", int'(bus0.tap_addr), 3);
    rst0 = 1'b0;
    step();
    chk("reset_mid_mac", all_out(0), 0);
    rst0 = 1'b1;
    outs = 0; lds = 0;
    for (int j = 7; j <= 14; j++) begin
      step();
      outs += int'(bus0.out_ld);
      if (j == 7) chk("restart_load", int'(bus0.sample_ld), 1);
      else        lds += int'(bus0.sample_ld);
    end
    chk("aborted_no_out_ld", outs, 0);
    chk("restart_single_load", lds, 0);
    step();
    chk("restart_out_ld", int'(bus0.out_ld), 1);

    // 4. external strobe with a second strobe 4 cycles later
    chk("ext_overrun_initial", int'(bus1.overrun), 0);
    bus1.sample_stb_i = 1'b1;
    lds = 0; outs = 0; out_at = -1;
    for (int j = 1; j <= 12; j++) begin
      step();
      bus1.sample_stb_i = (j == 4);
      lds += int'(bus1.sample_ld);
      if (bus1.out_ld) begin outs++; out_at = j; end
      if (j == 1) chk("ext_clk_r_copy", int'(bus1.clk_r), 1);
      if (j == 1) chk("ext_load_t1", int'(bus1.sample_ld), 1);
      if (j == 4) chk("ext_overrun_before", int'(bus1.overrun), 0);
      if (j == 5) chk("ext_overrun_set", int'(bus1.overrun), 1);
    end
    chk("ext_single_load", lds, 1);
    chk("ext_single_out_ld", outs, 1);
    chk("ext_out_ld_at", out_at, 9);
    for (int j = 0; j < 5; j++) step();
    chk("ext_overrun_sticky", int'(bus1.overrun), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
